// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU arbiter onto one single-ported memory interface
// Optional build macro ARB_RR_EN: round-robin grant on ties (default: LSU priority).
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_data,
  output logic          ifu_rsp_err,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic [AW-1:0] lsu_addr,
  input  logic          lsu_wen,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [2:0]    lsu_wlen,
  output logic          lsu_rsp_valid,
  input  logic          lsu_rsp_ready,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          lsu_rsp_err,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_wlen,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_data,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    wlen_q, wlen_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   cnt_q, cnt_d;

  logic grant_lsu;
  logic grant_ifu;
  logic wlen_ok;

`ifdef ARB_RR_EN
  // On a tie, hand the memory to whoever did not own the last transaction.
  assign grant_lsu = lsu_req_valid && (!ifu_req_valid || !owner_q);
`else
  assign grant_lsu = lsu_req_valid;
`endif
  assign grant_ifu = ifu_req_valid && !grant_lsu;

  assign wlen_ok = (lsu_wlen == 3'b001) || (lsu_wlen == 3'b010) || (lsu_wlen == 3'b100);

  // State and latched-command registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wlen_q  <= 3'b000;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wlen_q  <= wlen_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and request handshakes.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wlen_d        = wlen_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
        if (grant_lsu) begin
          owner_d = 1'b1;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wen ? lsu_wdata : '0;
          wlen_d  = lsu_wen ? lsu_wlen : 3'b000;
          rdata_d = '0;
          err_d   = 1'b0;
          // Illegal store length never reaches the memory.
          if (lsu_wen && !wlen_ok) begin
            err_d   = 1'b1;
            state_d = RSP;
          end else begin
            state_d = REQ;
          end
        end else if (grant_ifu) begin
          owner_d = 1'b0;
          addr_d  = ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wlen_d  = 3'b000;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          rdata_d = wen_q ? '0 : mem_rsp_data;
          err_d   = 1'b0;
          state_d = RSP;
        end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RSP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RSP: begin
        if (owner_q ? lsu_rsp_ready : ifu_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wlen      = wlen_q;

  assign ifu_rsp_valid = (state_q == RSP) && !owner_q;
  assign lsu_rsp_valid = (state_q == RSP) && owner_q;
  assign ifu_rsp_data  = rdata_q;
  assign lsu_rsp_rdata = rdata_q;
  assign ifu_rsp_err   = ifu_rsp_valid && err_q;
  assign lsu_rsp_err   = lsu_rsp_valid && err_q;

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule
